// File: rtl/tlight_sched.sv
// tlight_sched -- demand-responsive phase scheduler for a two-way intersection.
//
// Cycles the north-south (ns) and west-east (we) heads through
// green -> yellow -> all-red, serves latched pedestrian walk requests and,
// when built with TLIGHT_EMERG_EN, preempts for an emergency vehicle.
// Green is never granted to both directions at once.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset (state AR_B, all lamps red)
//   ped_ns_req  walk request for the ns-parallel crossing, sampled every edge
//   ped_we_req  walk request for the we-parallel crossing, sampled every edge
//   emerg_req   emergency preemption request (level)
//   emerg_dir   preempted direction: 0 = ns, 1 = we
//   ns, we      one-hot heads {red, yellow, green}
//   walk_ns     ns-parallel walk lamp
//   walk_we     we-parallel walk lamp
//   phase       current state code
//
// Build option: define TLIGHT_EMERG_EN to build emergency preemption; without
// it emerg_req/emerg_dir are ignored and phase never reaches 6.
module tlight_sched #(
   parameter int YELLOW_TIME = 3,
   parameter int ALLRED_TIME = 1,
   parameter int GREEN_MIN   = 5,
   parameter int GREEN_MAX   = 15,
   parameter int WALK_TIME   = 4,
   parameter int CW          = 5
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ped_ns_req,
   input  logic       ped_we_req,
   input  logic       emerg_req,
   input  logic       emerg_dir,
   output logic [2:0] ns,
   output logic [2:0] we,
   output logic       walk_ns,
   output logic       walk_we,
   output logic [2:0] phase
);

   localparam logic [2:0] NS_G = 3'd0;
   localparam logic [2:0] NS_Y = 3'd1;
   localparam logic [2:0] AR_A = 3'd2;
   localparam logic [2:0] WE_G = 3'd3;
   localparam logic [2:0] WE_Y = 3'd4;
   localparam logic [2:0] AR_B = 3'd5;
   localparam logic [2:0] EMG  = 3'd6;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam logic [CW-1:0] Y_LAST    = CW'(YELLOW_TIME - 1);
   localparam logic [CW-1:0] AR_LAST   = CW'(ALLRED_TIME - 1);
   localparam logic [CW-1:0] G_LAST    = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] GMIN_LAST = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] WALK_LEN  = CW'(WALK_TIME);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_ns_q, pend_ns_d;
   logic          pend_we_q, pend_we_d;
   logic          walk_ns_q, walk_ns_d;
   logic          walk_we_q, walk_we_d;
   logic [2:0]    ns_q, ns_d;
   logic [2:0]    we_q, we_d;

   logic          preempt_s;     // preemption requested this cycle
   logic          pre_dir_s;     // direction preemption is heading for
   logic          ns_exit_s;     // normal ns green exit
   logic          we_exit_s;     // normal we green exit
   logic          enter_ns_g_s;
   logic          enter_we_g_s;

`ifdef TLIGHT_EMERG_EN
   logic emg_on_q, emg_on_d;
   logic emg_dir_q, emg_dir_d;

   // Direction is captured on the first cycle of a request and held until it drops
   always_comb begin
      emg_on_d = emerg_req;
      if (emerg_req && !emg_on_q) begin
         emg_dir_d = emerg_dir;
      end else begin
         emg_dir_d = emg_dir_q;
      end
   end

   assign preempt_s = emerg_req;
   assign pre_dir_s = emg_on_q ? emg_dir_q : emerg_dir;

   // Emergency latch registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         emg_on_q  <= 1'b0;
         emg_dir_q <= 1'b0;
      end else begin
         emg_on_q  <= emg_on_d;
         emg_dir_q <= emg_dir_d;
      end
   end
`else
   logic unused_emerg_s;
   assign unused_emerg_s = emerg_req ^ emerg_dir;
   assign preempt_s      = 1'b0;
   assign pre_dir_s      = 1'b0;
`endif

   // A green may end at its maximum, or early once the minimum is served and the cross side waits
   assign ns_exit_s = (cnt_q == G_LAST) || ((cnt_q >= GMIN_LAST) && pend_we_q);
   assign we_exit_s = (cnt_q == G_LAST) || ((cnt_q >= GMIN_LAST) && pend_ns_q);

   // Next phase: dwell expiry, pedestrian truncation and preemption
   always_comb begin
      state_d = state_q;
      case (state_q)
         NS_G: begin
            if (preempt_s && !pre_dir_s) begin
               state_d = EMG;
            end else if (preempt_s || ns_exit_s) begin
               state_d = NS_Y;
            end else begin
               state_d = NS_G;
            end
         end
         WE_G: begin
            if (preempt_s && pre_dir_s) begin
               state_d = EMG;
            end else if (preempt_s || we_exit_s) begin
               state_d = WE_Y;
            end else begin
               state_d = WE_G;
            end
         end
         NS_Y: begin
            if (cnt_q == Y_LAST) state_d = AR_A;
            else                 state_d = NS_Y;
         end
         WE_Y: begin
            if (cnt_q == Y_LAST) state_d = AR_B;
            else                 state_d = WE_Y;
         end
         AR_A: begin
            if (cnt_q == AR_LAST) state_d = preempt_s ? EMG : WE_G;
            else                  state_d = AR_A;
         end
         AR_B: begin
            if (cnt_q == AR_LAST) state_d = preempt_s ? EMG : NS_G;
            else                  state_d = AR_B;
         end
`ifdef TLIGHT_EMERG_EN
         EMG: begin
            if (!emerg_req) state_d = emg_dir_q ? WE_Y : NS_Y;
            else            state_d = EMG;
         end
`endif
         default: state_d = AR_B;
      endcase
   end

   assign enter_ns_g_s = (state_d == NS_G) && (state_q != NS_G);
   assign enter_we_g_s = (state_d == WE_G) && (state_q != WE_G);

   // Dwell counter, pedestrian latches (entry clear beats a same-edge request) and walk lamps
   always_comb begin
      if (state_d != state_q) cnt_d = '0;
      else                    cnt_d = cnt_q + CW'(1);

      if (enter_ns_g_s) pend_ns_d = 1'b0;
      else              pend_ns_d = pend_ns_q | ped_ns_req;
      if (enter_we_g_s) pend_we_d = 1'b0;
      else              pend_we_d = pend_we_q | ped_we_req;

      // Walk is granted only if the latch was pending when the green began
      if (enter_ns_g_s)           walk_ns_d = pend_ns_q;
      else if (state_d == NS_G)   walk_ns_d = walk_ns_q && (cnt_d < WALK_LEN);
      else                        walk_ns_d = 1'b0;
      if (enter_we_g_s)           walk_we_d = pend_we_q;
      else if (state_d == WE_G)   walk_we_d = walk_we_q && (cnt_d < WALK_LEN);
      else                        walk_we_d = 1'b0;
   end

   // Lamp decode of the upcoming state so the heads come straight from flops
   always_comb begin
      ns_d = LAMP_R;
      we_d = LAMP_R;
      case (state_d)
         NS_G:    ns_d = LAMP_G;
         NS_Y:    ns_d = LAMP_Y;
         WE_G:    we_d = LAMP_G;
         WE_Y:    we_d = LAMP_Y;
         AR_A:    ns_d = LAMP_R;
         AR_B:    ns_d = LAMP_R;
`ifdef TLIGHT_EMERG_EN
         EMG: begin
            if (emg_dir_d) we_d = LAMP_G;
            else           ns_d = LAMP_G;
         end
`endif
         default: ns_d = LAMP_R;
      endcase
   end

   // Phase state, dwell counter, latches and registered lamp outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= AR_B;
         cnt_q     <= '0;
         pend_ns_q <= 1'b0;
         pend_we_q <= 1'b0;
         walk_ns_q <= 1'b0;
         walk_we_q <= 1'b0;
         ns_q      <= LAMP_R;
         we_q      <= LAMP_R;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_ns_q <= pend_ns_d;
         pend_we_q <= pend_we_d;
         walk_ns_q <= walk_ns_d;
         walk_we_q <= walk_we_d;
         ns_q      <= ns_d;
         we_q      <= we_d;
      end
   end

   assign ns      = ns_q;
   assign we      = we_q;
   assign walk_ns = walk_ns_q;
   assign walk_we = walk_we_q;
   assign phase   = state_q;

endmodule

// File: tb/tb_tlight_sched.sv
`timescale 1ns/1ps
module tb_tlight_sched;

   localparam int YT   = 3;
   localparam int AT   = 1;
   localparam int GMIN = 5;
   localparam int GMAX = 15;
   localparam int WT   = 4;
   localparam int CWID = 5;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ped_ns_req = 1'b0;
   logic       ped_we_req = 1'b0;
   logic       emerg_req = 1'b0;
   logic       emerg_dir = 1'b0;
   logic [2:0] ns, we, phase;
   logic       walk_ns, walk_we;

   int checks = 0;
   int errors = 0;

   tlight_sched #(
      .YELLOW_TIME(YT), .ALLRED_TIME(AT), .GREEN_MIN(GMIN),
      .GREEN_MAX(GMAX), .WALK_TIME(WT), .CW(CWID)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .ped_ns_req(ped_ns_req), .ped_we_req(ped_we_req),
      .emerg_req(emerg_req), .emerg_dir(emerg_dir),
      .ns(ns), .we(we), .walk_ns(walk_ns), .walk_we(walk_we), .phase(phase)
   );

   always #5 clock = ~clock;

   // ---------------- reference model (phase, age in phase, walk countdowns) ----------------
   int m_ph;
   int m_held;
   int m_walk[2];
   bit m_pend[2];
   bit m_emg_on;
   bit m_emg_dir;

   task automatic model_reset();
      m_ph = 5; m_held = 0;
      m_walk[0] = 0; m_walk[1] = 0;
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
      m_emg_on = 1'b0; m_emg_dir = 1'b0;
   endtask

   function automatic int fixed_dwell(int ph);
      if (ph == 1 || ph == 4) return YT;
      return AT;
   endfunction

   task automatic model_step(bit pn, bit pw, bit er, bit ed);
      int nxt, age, gdir, g;
      bit pre, pdir, req;
      age  = m_held + 1;
      pre  = 1'b0;
`ifdef TLIGHT_EMERG_EN
      pre  = er;
`endif
      pdir = m_emg_on ? m_emg_dir : ed;
      nxt  = m_ph;
      if (m_ph == 0 || m_ph == 3) begin
         gdir = (m_ph == 3) ? 1 : 0;
         if (pre && int'(pdir) == gdir) nxt = 6;
         else if (pre || age >= GMAX || (age >= GMIN && m_pend[1 - gdir])) nxt = m_ph + 1;
      end else if (m_ph == 6) begin
         if (!er) nxt = m_emg_dir ? 4 : 1;
      end else if (age >= fixed_dwell(m_ph)) begin
         if (m_ph == 1 || m_ph == 4) nxt = m_ph + 1;
         else nxt = pre ? 6 : (m_ph + 1) % 6;
      end
      for (int d = 0; d < 2; d++) begin
         g   = 3 * d;
         req = (d == 1) ? pw : pn;
         if (nxt == g && m_ph != g) begin
            m_walk[d] = m_pend[d] ? WT : 0;
            m_pend[d] = 1'b0;
         end else begin
            m_pend[d] = m_pend[d] | req;
            m_walk[d] = (nxt == g && m_walk[d] > 0) ? m_walk[d] - 1 : 0;
         end
      end
      if (er && !m_emg_on) m_emg_dir = ed;
      m_emg_on = er;
      m_held = (nxt != m_ph) ? 0 : m_held + 1;
      m_ph = nxt;
   endtask

   function automatic logic [10:0] model_vec();
      logic [2:0] ens, ewe;
      ens = 3'b100; ewe = 3'b100;
      case (m_ph)
         0: ens = 3'b001;
         1: ens = 3'b010;
         3: ewe = 3'b001;
         4: ewe = 3'b010;
         6: if (m_emg_dir) ewe = 3'b001; else ens = 3'b001;
         default: ens = 3'b100;
      endcase
      return {3'(m_ph), ens, ewe, (m_walk[0] > 0) ? 1'b1 : 1'b0, (m_walk[1] > 0) ? 1'b1 : 1'b0};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {phase, ns, we, walk_ns, walk_we};
   endfunction

   // Drive inputs, advance one clock, update the model, stop at the falling edge
   task automatic tick(input bit pn, input bit pw, input bit er, input bit ed);
      ped_ns_req = pn; ped_we_req = pw; emerg_req = er; emerg_dir = ed;
      @(posedge clock);
      model_step(pn, pw, er, ed);
      @(negedge clock);
   endtask

   // Idle until the model sits in NS_G at the given dwell count
   task automatic align_ns_g(input int cnt_want, input string tag);
      int n;
      n = 0;
      while (!(m_ph == 0 && m_held == cnt_want) && n < 200) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         n++;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL %s_align: got %h want %h", tag, dut_vec(), model_vec());
         end
      end
      checks++;
      if (n >= 200) begin
         errors++; $display("FAIL %s_align_timeout: got %0d cycles want <200", tag, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [10:0] exp_v;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      exp_v = {3'd5, 3'b100, 3'b100, 1'b0, 1'b0};
      checks++;
      if (dut_vec() !== exp_v) begin
         errors++; $display("FAIL reset_values: got %h want %h", dut_vec(), exp_v);
      end
   endtask

   task automatic test_nominal();
      int obs[76];
      int c_ns, c_we;
      bit per_ok;
      reset_n = 1'b1;
      checks++;
      if (phase !== 3'd5) begin
         errors++; $display("FAIL release_phase: got %0d want 5", phase);
      end
      for (int k = 0; k < 76; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         obs[k] = int'(phase);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL nominal_cyc%0d: got %h want %h", k, dut_vec(), model_vec());
         end
         checks++;
         if (ns !== 3'b100 && we !== 3'b100) begin
            errors++; $display("FAIL nominal_safety: got ns %b we %b want one red", ns, we);
         end
      end
      checks++;
      if (obs[0] != 0) begin
         errors++; $display("FAIL first_green: got %0d want 0", obs[0]);
      end
      c_ns = 0; c_we = 0;
      for (int k = 0; k < 38; k++) begin
         if (obs[k] == 0) c_ns++;
         if (obs[k] == 3) c_we++;
      end
      checks++;
      if (c_ns != GMAX || c_we != GMAX) begin
         errors++; $display("FAIL green_len: got ns %0d we %0d want %0d", c_ns, c_we, GMAX);
      end
      per_ok = 1'b1;
      for (int k = 0; k < 38; k++) if (obs[k] != obs[k + 2 * (GMAX + YT + AT)]) per_ok = 1'b0;
      checks++;
      if (!per_ok) begin
         errors++; $display("FAIL period: got mismatch want period %0d", 2 * (GMAX + YT + AT));
      end
   endtask

   task automatic test_ped_we();
      int c, w, len, k;
      align_ns_g(2, "pedwe");
      c = 0;
      while (phase === 3'd0 && c < 40) begin
         tick(1'b0, (c == 0), 1'b0, 1'b0);
         c++;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL pedwe_ns: got %h want %h", dut_vec(), model_vec());
         end
      end
      checks++;
      if (2 + c != GMIN) begin
         errors++; $display("FAIL pedwe_truncate: got %0d want %0d", 2 + c, GMIN);
      end
      k = 0;
      while (phase !== 3'd3 && k < 40) begin tick(1'b0, 1'b0, 1'b0, 1'b0); k++; end
      w = 0; len = 0;
      while (phase === 3'd3 && len < 40) begin
         if (walk_we === 1'b1) w++;
         len++;
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL pedwe_we: got %h want %h", dut_vec(), model_vec());
         end
      end
      checks++;
      if (w != WT || len != GMAX) begin
         errors++; $display("FAIL pedwe_walk: got walk %0d len %0d want %0d %0d", w, len, WT, GMAX);
      end
   endtask

   task automatic test_ped_ns_held();
      int k, wn, len;
      k = 0;
      while (phase !== 3'd0 && k < 60) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         k++;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL pedns_pre: got %h want %h", dut_vec(), model_vec());
         end
      end
      wn = 0; k = 0;
      while (phase === 3'd0 && k < 40) begin
         if (walk_ns === 1'b1) wn++;
         tick((k < 2), 1'b0, 1'b0, 1'b0);
         k++;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL pedns_ns: got %h want %h", dut_vec(), model_vec());
         end
      end
      checks++;
      if (wn != WT || k != GMAX) begin
         errors++; $display("FAIL pedns_walk: got walk %0d len %0d want %0d %0d", wn, k, WT, GMAX);
      end
      k = 0;
      while (phase !== 3'd3 && k < 40) begin tick(1'b0, 1'b0, 1'b0, 1'b0); k++; end
      len = 0;
      while (phase === 3'd3 && len < 40) begin
         len++;
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL pedns_we: got %h want %h", dut_vec(), model_vec());
         end
      end
      checks++;
      if (len != GMIN) begin
         errors++; $display("FAIL pedns_we_truncate: got %0d want %0d", len, GMIN);
      end
   endtask

   task automatic test_back_to_back();
      int c, k, w, len;
      align_ns_g(1, "both");
      c = 0;
      while (phase === 3'd0 && c < 40) begin
         tick((c == 0), (c == 0), 1'b0, 1'b0);
         c++;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL both_ns: got %h want %h", dut_vec(), model_vec());
         end
      end
      checks++;
      if (1 + c != GMIN) begin
         errors++; $display("FAIL both_ns_truncate: got %0d want %0d", 1 + c, GMIN);
      end
      k = 0;
      while (phase !== 3'd3 && k < 40) begin tick(1'b0, 1'b0, 1'b0, 1'b0); k++; end
      w = 0; len = 0;
      while (phase === 3'd3 && len < 40) begin
         if (walk_we === 1'b1) w++;
         len++;
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL both_we: got %h want %h", dut_vec(), model_vec());
         end
      end
      checks++;
      if (w != WT || len != GMIN) begin
         errors++; $display("FAIL both_we_walk: got walk %0d len %0d want %0d %0d", w, len, WT, GMIN);
      end
   endtask

   task automatic test_emergency();
      int c, y, a;
      bit saw6;
      align_ns_g(1, "emg");
`ifdef TLIGHT_EMERG_EN
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (phase !== 3'd1) begin
         errors++; $display("FAIL emg_to_yellow: got %0d want 1", phase);
      end
      y = 0;
      while (phase === 3'd1 && y < 20) begin y++; tick(1'b0, 1'b0, 1'b1, 1'b1); end
      a = 0;
      while (phase === 3'd2 && a < 20) begin a++; tick(1'b0, 1'b0, 1'b1, 1'b1); end
      checks++;
      if (y != YT || a != AT) begin
         errors++; $display("FAIL emg_clearance: got y %0d ar %0d want %0d %0d", y, a, YT, AT);
      end
      saw6 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (phase !== 3'd6 || we !== 3'b001 || ns !== 3'b100) saw6 = 1'b0;
         tick(1'b0, 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (!saw6) begin
         errors++; $display("FAIL emg_hold: got phase %0d we %b want 6 001", phase, we);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (phase !== 3'd4) begin
         errors++; $display("FAIL emg_release: got %0d want 4", phase);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++; $display("FAIL emg_model: got %h want %h", dut_vec(), model_vec());
      end
`else
      c = 0; y = 0; a = 0; saw6 = 1'b0;
      while (phase === 3'd0 && c < 40) begin
         tick(1'b0, 1'b0, 1'b1, 1'b1);
         c++;
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL noemg_ns: got %h want %h", dut_vec(), model_vec());
         end
      end
      checks++;
      if (1 + c != GMAX) begin
         errors++; $display("FAIL noemg_green_len: got %0d want %0d", 1 + c, GMAX);
      end
      for (int k = 0; k < 40; k++) begin
         tick(1'b0, 1'b0, 1'b1, k[0]);
         if (phase === 3'd6) saw6 = 1'b1;
      end
      checks++;
      if (saw6) begin
         errors++; $display("FAIL noemg_phase6: got 6 want never");
      end
`endif
   endtask

   task automatic test_random();
      bit pn, pw, er, ed;
      er = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         pn = ($urandom_range(0, 19) == 0);
         pw = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 39) == 0) er = !er;
         ed = 1'($urandom_range(0, 1));
         tick(pn, pw, er, ed);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL random_cyc%0d: got %h want %h", k, dut_vec(), model_vec());
         end
         checks++;
         if (ns !== 3'b100 && we !== 3'b100) begin
            errors++; $display("FAIL random_safety: got ns %b we %b want one red", ns, we);
         end
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      int n;
      logic [10:0] exp_v;
      n = 0;
      while (m_ph != 4 && n < 300) begin tick(1'b0, 1'b0, 1'b0, 1'b0); n++; end
      checks++;
      if (phase !== 3'd4) begin
         errors++; $display("FAIL areset_reach_we_y: got %0d want 4", phase);
      end
      #2 reset_n = 1'b0;
      #1;
      exp_v = {3'd5, 3'b100, 3'b100, 1'b0, 1'b0};
      checks++;
      if (dut_vec() !== exp_v) begin
         errors++; $display("FAIL areset_immediate: got %h want %h", dut_vec(), exp_v);
      end
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL areset_resume: got %h want %h", dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_ped_we();
      test_ped_ns_held();
      test_back_to_back();
      test_emergency();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlight_sched.md
# tlight_sched

Demand-responsive phase scheduler for a two-way intersection. It sequences the north-south (ns) and west-east (we) signal heads through green, yellow and all-red phases. It also serves latched pedestrian walk requests and optionally preempts for an emergency vehicle. It sits above the lamp drivers and is the single owner of the shared intersection: it never grants green to both directions at once.

## Interface
- YELLOW_TIME, 3: yellow dwell, cycles (≥1)
- ALLRED_TIME, 1: all-red clearance dwell, cycles (≥1)
- GREEN_MIN, 5: minimum green dwell, cycles (≥WALK_TIME, ≥1)
- GREEN_MAX, 15: maximum green dwell, cycles (>GREEN_MIN)
- WALK_TIME, 4: walk indication length, cycles (≥1)
- CW, 5: dwell counter width; must hold GREEN_MAX-1
- clock  in  1  rising-edge clock, period 1 s
- reset_n  in  1  asynchronous, active-low reset
- ped_ns_req  in  1  walk request for crossing parallel to ns flow; sampled each edge
- ped_we_req  in  1  walk request for crossing parallel to we flow
- emerg_req  in  1  emergency preemption request, level
- emerg_dir  in  1  preempted direction: 0 = ns, 1 = we
- ns  out  3  ns head, one-hot {red, yellow, green}: 100 / 010 / 001
- we  out  3  we head, same encoding
- walk_ns  out  1  ns-parallel walk lamp
- walk_we  out  1  we-parallel walk lamp
- phase  out  3  current state code (debug and verification)

## Operation
- States and phase codes:
  - NS_G = 0, NS_Y = 1, AR_A = 2, WE_G = 3, WE_Y = 4, AR_B = 5, EMG = 6.
  - Cyclic order: NS_G → NS_Y → AR_A → WE_G → WE_Y → AR_B → NS_G.
- Lamps are a pure function of registered state:
  - NS_G: ns = green, we = red.
  - NS_Y: ns = yellow, we = red.
  - WE_G / WE_Y: mirror of NS_G / NS_Y.
  - AR_A / AR_B: both red.
  - EMG: green on the latched direction, red on the other.
- Dwell counter cnt: cleared to 0 on every state entry, increments each cycle.
- Exit conditions:
  - Yellow exits when cnt == YELLOW_TIME-1.
  - All-red exits when cnt == ALLRED_TIME-1.
  - Green exits when cnt == GREEN_MAX-1.
  - Green also exits early when cnt ≥ GREEN_MIN-1 and a cross request is pending. The cross request for NS_G is ped_we pending; for WE_G it is ped_ns pending.
- Pedestrian latches pend_ns and pend_we:
  - Set by a high request sampled on any edge.
  - pend_ns clears on the edge that enters NS_G; pend_we clears on the edge that enters WE_G.
  - Request and clear on the same edge: clear wins. A request arriving during that direction's green is held for its next green.
- Walk lamps:
  - walk_ns is high for the first WALK_TIME cycles of NS_G, only if pend_ns was set at entry. walk_we is analogous.
  - Walk is forced low in every other state.
- Reset: state AR_B, cnt 0, latches clear, emergency latch clear. Outputs: ns = we = 100, walk_ns = walk_we = 0, phase = 5.

## Timing
- Outputs change on the clock edge after the exit condition is true. No combinational path from inputs to outputs.
- Nominal cycle with no requests, defaults: NS green 15, yellow 3, all-red 1, then the same for we. Period is 38 cycles.
- Reset release: AR_B for ALLRED_TIME cycles, then NS_G.
- reset_n low mid-phase: immediate return to reset values, no yellow.
- Simultaneous ped_ns_req and ped_we_req: both latch. The current green truncates, then the walk is served on the cross green.

## Configuration
- TLIGHT_EMERG_EN defined: preemption is active.
  - emerg_dir is latched when preemption starts.
  - In the green of the latched direction: go to EMG next edge. cnt restarts and walk drops.
  - In the other green: go to its yellow immediately, ignoring GREEN_MIN. Then all-red, then EMG.
  - Yellow and all-red always complete their full dwell.
  - EMG holds while emerg_req is high. On drop it goes to the latched direction's yellow and resumes the normal cycle.
  - Pedestrian latches keep collecting during preemption.
- TLIGHT_EMERG_EN undefined: EMG state is not built. emerg_req and emerg_dir are ignored, and phase never equals 6.

## Test plan
- Reset low, then release, no requests: phase 5 for 1 cycle, NS_G for 15, NS_Y for 3, AR_A for 1, WE_G for 15. ns/we never both non-red.
- ped_we_req pulse at NS_G cnt = 2: NS_G exits after cnt = 4 (5 cycles total). In WE_G, walk_we is high for 4 cycles and pend_we is cleared.
- ped_ns_req held high across the NS_G entry edge: latch clears on entry and re-sets from the held request. walk_ns is 1 for 4 cycles. The next WE_G truncates to 5 cycles.
- With TLIGHT_EMERG_EN, emerg_req = 1 and emerg_dir = 1 during NS_G cnt = 1: NS_Y 3 cycles, AR_A 1, then phase 6 with we = 001. Drop emerg_req: WE_Y next edge.
- Without TLIGHT_EMERG_EN, same stimulus: sequence identical to the no-request case.
- reset_n asserted during WE_Y: ns = we = 100, walk low, phase 5 immediately, asynchronous to the clock.
